// File: rtl/avaliacao_pkg.sv
// Shared types and widths for the evaluation datapath (capture front end,
// principal and their benches).
package avaliacao_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } estado_t;

   localparam int DEBOUNCE_DEF = 4;
   localparam int E_W          = 2;
   localparam int P_W          = 4;

   // Button plus both switch groups travel through one synchroniser.
   localparam int SYNC_W       = 1 + E_W + P_W;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser for asynchronous board inputs; flops clear to 0
// on reset so a held input is seen as a fresh edge once reset releases.
module sincronizador #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/captura_avaliacao.sv
// Input-capture front end: synchronises switches and confirm button,
// debounces the button and latches the switches once per accepted press.
module captura_avaliacao
   import avaliacao_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] sw_e,
   input  logic [3:0] sw_p,
   input  logic       btn_ok,
   output logic       e1,
   output logic       e0,
   output logic       p3,
   output logic       p2,
   output logic       p1,
   output logic       p0,
   output logic       valid,
   output logic [3:0] n_capt,
   output logic       busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE       = IDLE;
   localparam logic [1:0] S_DB_PRESS   = DB_PRESS;
   localparam logic [1:0] S_HELD       = HELD;
   localparam logic [1:0] S_DB_RELEASE = DB_RELEASE;

   logic [SYNC_W-1:0] raw_in;
   logic [SYNC_W-1:0] sync_out;
   logic              btn_s;
   logic [E_W-1:0]    e_s;
   logic [P_W-1:0]    p_s;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [E_W-1:0]    e_q, e_d;
   logic [P_W-1:0]    p_q, p_d;
   logic [3:0]        n_capt_q, n_capt_d;
   logic              valid_q;
   logic              busy_q;
   logic              capture;

   assign raw_in = {btn_ok, sw_e, sw_p};

   sincronizador #(
      .W (SYNC_W)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (raw_in),
      .q_o   (sync_out)
   );

   assign btn_s = sync_out[SYNC_W-1];
   assign e_s   = sync_out[P_W +: E_W];
   assign p_s   = sync_out[P_W-1:0];

   // Press and release both need DEBOUNCE_CYCLES consecutive equal samples;
   // any opposite sample restarts from the stable state it came from.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (btn_s) begin
               state_d = S_DB_PRESS;
               cnt_d   = CNT_ONE;
            end
         end
         S_DB_PRESS: begin
            if (!btn_s) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HELD;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         S_HELD: begin
            if (!btn_s) begin
               state_d = S_DB_RELEASE;
               cnt_d   = CNT_ONE;
            end
         end
         S_DB_RELEASE: begin
            if (btn_s) begin
               state_d = S_HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Switches are sampled on the capture edge itself, not at press start.
   always_comb begin
      e_d      = e_q;
      p_d      = p_q;
      n_capt_d = n_capt_q;
      if (capture) begin
         e_d      = e_s;
         p_d      = p_s;
         n_capt_d = n_capt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         e_q      <= '0;
         p_q      <= '0;
         n_capt_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         e_q      <= e_d;
         p_q      <= p_d;
         n_capt_q <= n_capt_d;
         valid_q  <= capture;
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign e1     = e_q[1];
   assign e0     = e_q[0];
   assign p3     = p_q[3];
   assign p2     = p_q[2];
   assign p1     = p_q[1];
   assign p0     = p_q[0];
   assign valid  = valid_q;
   assign n_capt = n_capt_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_captura_avaliacao.sv
// Directed bench for captura_avaliacao with DEBOUNCE_CYCLES=4; one task per
// scenario, expected values hand-derived from the edge timing.
module tb_captura_avaliacao;

   logic       clk;
   logic       rst_n;
   logic [1:0] sw_e;
   logic [3:0] sw_p;
   logic       btn_ok;
   logic       e1, e0, p3, p2, p1, p0;
   logic       valid;
   logic [3:0] n_capt;
   logic       busy;

   logic [1:0] e_o;
   logic [3:0] p_o;

   int total;
   int bad;

   assign e_o = {e1, e0};
   assign p_o = {p3, p2, p1, p0};

   captura_avaliacao #(
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_e   (sw_e),
      .sw_p   (sw_p),
      .btn_ok (btn_ok),
      .e1     (e1),
      .e0     (e0),
      .p3     (p3),
      .p2     (p2),
      .p1     (p1),
      .p0     (p0),
      .valid  (valid),
      .n_capt (n_capt),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: drop the button and wait past the release debounce.
   task automatic release_btn();
      btn_ok = 1'b0;
      repeat (7) tick();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      btn_ok = 1'b0;
      sw_e   = 2'b11;
      sw_p   = 4'b1111;
      repeat (3) tick();
      total++;
      if ({e_o, p_o} !== 6'b0) begin
         bad++;
         $display("FAIL reset_outs got=%b want=000000", {e_o, p_o});
      end
      total++;
      if ({valid, busy, n_capt} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=000000", {valid, busy, n_capt});
      end
      rst_n = 1'b1;
      repeat (4) tick();
      total++;
      if ({e_o, p_o, valid, busy, n_capt} !== 12'b0) begin
         bad++;
         $display("FAIL reset_idle got=%b want=0", {e_o, p_o, valid, busy, n_capt});
      end
   endtask

   task automatic test_clean_press();
      sw_e   = 2'b10;
      sw_p   = 4'b1011;
      btn_ok = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (valid !== (i == 6)) begin
            bad++;
            $display("FAIL clean_valid tick=%0d got=%b want=%b", i, valid, (i == 6));
         end
         if (i == 2 || i == 3) begin
            total++;
            if (busy !== (i == 3)) begin
               bad++;
               $display("FAIL clean_busy tick=%0d got=%b want=%b", i, busy, (i == 3));
            end
         end
         if (i == 5) begin
            total++;
            if (p_o !== 4'b0000) begin
               bad++;
               $display("FAIL clean_early_p got=%b want=0000", p_o);
            end
         end
      end
      total++;
      if ({e_o, p_o, n_capt} !== {2'b10, 4'b1011, 4'd1}) begin
         bad++;
         $display("FAIL clean_latch got=%b_%b_%0d want=10_1011_1", e_o, p_o, n_capt);
      end
      release_btn();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL clean_release_busy got=%b want=0", busy);
      end
   endtask

   task automatic test_bouncy();
      logic [5:0] pat;
      pat  = 6'b101101;
      sw_e = 2'b01;
      sw_p = 4'b0110;
      for (int i = 0; i < 20; i++) begin
         btn_ok = (i < 6) ? pat[i] : 1'b1;
         tick();
         total++;
         if (valid !== (i == 10)) begin
            bad++;
            $display("FAIL bouncy_valid step=%0d got=%b want=%b", i, valid, (i == 10));
         end
      end
      total++;
      if ({e_o, p_o, n_capt} !== {2'b01, 4'b0110, 4'd2}) begin
         bad++;
         $display("FAIL bouncy_latch got=%b_%b_%0d want=01_0110_2", e_o, p_o, n_capt);
      end
      release_btn();
   endtask

   task automatic test_switch_held();
      int nv;
      sw_e   = 2'b10;
      sw_p   = 4'b1011;
      btn_ok = 1'b1;
      repeat (8) tick();
      total++;
      if ({p_o, n_capt} !== {4'b1011, 4'd3}) begin
         bad++;
         $display("FAIL held_first got=%b_%0d want=1011_3", p_o, n_capt);
      end
      sw_p = 4'b0001;
      sw_e = 2'b01;
      nv   = 0;
      repeat (6) begin
         tick();
         if (valid) nv++;
      end
      total++;
      if ({e_o, p_o} !== {2'b10, 4'b1011} || nv != 0) begin
         bad++;
         $display("FAIL held_ignore got=%b_%b pulses=%0d want=10_1011 pulses=0", e_o, p_o, nv);
      end
      release_btn();
      btn_ok = 1'b1;
      repeat (8) tick();
      total++;
      if ({e_o, p_o, n_capt} !== {2'b01, 4'b0001, 4'd4}) begin
         bad++;
         $display("FAIL held_next got=%b_%b_%0d want=01_0001_4", e_o, p_o, n_capt);
      end
      release_btn();
   endtask

   task automatic test_release_glitch();
      int nv;
      btn_ok = 1'b1;
      repeat (8) tick();
      total++;
      if (n_capt !== 4'd5) begin
         bad++;
         $display("FAIL glitch_press got=%0d want=5", n_capt);
      end
      sw_p = 4'b1111;
      nv   = 0;
      for (int k = 0; k < 10; k++) begin
         btn_ok = (k == 2);
         tick();
         if (valid) nv++;
         if (k == 5) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL glitch_rehold got=%b want=1", busy);
            end
         end
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_idle got=%b want=0", busy);
      end
      total++;
      if (nv != 0 || n_capt !== 4'd5 || p_o !== 4'b0001) begin
         bad++;
         $display("FAIL glitch_nocapt got=pulses%0d_n%0d_p%b want=pulses0_n5_p0001", nv, n_capt, p_o);
      end
   endtask

   task automatic test_reset_mid();
      int nv;
      sw_e   = 2'b11;
      sw_p   = 4'b1100;
      btn_ok = 1'b1;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({e_o, p_o, valid, busy, n_capt} !== 12'b0) begin
         bad++;
         $display("FAIL rstmid_async got=%b want=0", {e_o, p_o, valid, busy, n_capt});
      end
      repeat (2) tick();
      rst_n = 1'b1;
      nv    = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (valid) nv++;
         total++;
         if (valid !== (i == 6)) begin
            bad++;
            $display("FAIL rstmid_valid tick=%0d got=%b want=%b", i, valid, (i == 6));
         end
      end
      total++;
      if ({e_o, p_o, n_capt} !== {2'b11, 4'b1100, 4'd1} || nv != 1) begin
         bad++;
         $display("FAIL rstmid_latch got=%b_%b_%0d pulses=%0d want=11_1100_1 pulses=1", e_o, p_o, n_capt, nv);
      end
      release_btn();
   endtask

   task automatic test_wrap();
      int nv;
      btn_ok = 1'b0;
      rst_n  = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 16; k++) begin
         sw_p   = 4'(k);
         sw_e   = 2'(k);
         btn_ok = 1'b1;
         nv     = 0;
         repeat (6) begin
            tick();
            if (valid) nv++;
         end
         total++;
         if (valid !== 1'b1 || nv != 1 || n_capt !== 4'((k + 1) % 16) || p_o !== 4'(k)) begin
            bad++;
            $display("FAIL wrap_press k=%0d got=v%b_c%0d_n%0d_p%b want=v1_c1_n%0d_p%b",
                     k, valid, nv, n_capt, p_o, (k + 1) % 16, 4'(k));
         end
         release_btn();
      end
      total++;
      if (n_capt !== 4'd0) begin
         bad++;
         $display("FAIL wrap_final got=%0d want=0", n_capt);
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      btn_ok = 1'b0;
      sw_e   = 2'b00;
      sw_p   = 4'b0000;
      test_reset();
      test_clean_press();
      test_bouncy();
      test_switch_held();
      test_release_glitch();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
